tff_toggle_arbiter: RTL and testbench

- Shares one two-stage T flip-flop chain between N requesters.
- Each requester asks for a burst of toggle-enable cycles. The block grants requesters round-robin and drives the chain's T input (data) for exactly the requested count.
- An internal model of the chain is compared against the chain's q every cycle, and any mismatch is flagged.
- Sits between requester logic and the toggle-flop pair; data connects to the chain's data input and q_fb to its q output.

---
 rtl/tff_toggle_arbiter.sv | 111 +++++++++++
 tb/tb_tff_toggle_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one two-stage T flip-flop chain among N_REQ requesters.
// Drives the chain's T input for the granted burst length and cross-checks q_fb against a local chain model.
module tff_toggle_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_cnt,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   data,
  output logic                   done,
  input  logic                   q_fb,
  output logic                   err
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    ptr, cur, sel;
  logic [IW:0]      idx;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fld [N_REQ];
  logic [N_REQ-1:0] sel_oh;
  logic             q1_m, q_m;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fld
    assign fld[g] = req_cnt[g*CNT_W +: CNT_W];
  end

  // Walk the ring downward from ptr+N-1 to ptr so the nearest set request wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  assign sel_oh = {{(N_REQ-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      data  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt  <= sel_oh;
          busy <= 1'b1;
          cur  <= sel;
          cnt  <= fld[sel];
          if (fld[sel] != '0) begin
            data  <= 1'b1;
            state <= RUN;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            data  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          ptr   <= (cur == IW'(N_REQ-1)) ? '0 : cur + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow of the external chain; any divergence latches err until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_m <= 1'b0;
      q_m  <= 1'b0;
      err  <= 1'b0;
    end else begin
      q1_m <= q1_m ^ data;
      q_m  <= q_m ^ q1_m;
      if (q_fb != q_m) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench: stimulus predicts grant order and burst lengths, a negedge monitor checks each burst.
module tb_tff_toggle_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_cnt = '0;
  logic [N-1:0]   gnt;
  logic           busy, data, done, q_fb, err;
  logic           c1, cq, inj = 1'b0;

  tff_toggle_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cnt(req_cnt), .gnt(gnt),
    .busy(busy), .data(data), .done(done), .q_fb(q_fb), .err(err)
  );

  // The physical toggle-flop pair, with an optional inversion on its q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1 <= 1'b0;
      cq <= 1'b0;
    end else begin
      c1 <= c1 ^ data;
      cq <= cq ^ c1;
    end
  end
  assign q_fb = cq ^ inj;

  always #5 clk = ~clk;

  typedef struct { int id; int len; } exp_t;
  exp_t sbq[$];

  int errors = 0, checks = 0;
  int mptr = 0;
  bit err_exp = 1'b0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor
  bit           inb = 1'b0;
  logic [N-1:0] g0;
  int           dcnt = 0, last_done = -100;
  always @(negedge clk) begin
    exp_t e;
    if (rst) inb = 1'b0;
    else begin
      if (!busy) chk("idle_quiet", int'({gnt, data, done}), 0);
      if (busy && !inb) begin
        inb  = 1'b1;
        g0   = gnt;
        dcnt = 0;
        chk("gnt_onehot", int'($onehot(gnt)), 1);
        chk("gap_after_done", int'(cyc - last_done >= 2), 1);
      end
      if (inb) begin
        chk("gnt_stable", int'(gnt), int'(g0));
        if (data) dcnt++;
      end
      if (done) begin
        if (sbq.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
          e = sbq.pop_front();
          chk("grant_id", int'(gnt), 1 << e.id);
          chk("burst_len", dcnt, e.len);
          chk("err_at_done", int'(err), int'(err_exp));
        end
        last_done = cyc;
        inb = 1'b0;
      end
    end
  end

  // Issue one request set; every member is serviced once in ring order from the model pointer.
  task automatic run_round(input logic [N-1:0] m, input logic [N*W-1:0] cnts, input int inj_cyc);
    int id, last;
    bit ok;
    exp_t e;
    @(posedge clk); #1;
    req_cnt = cnts;
    req     = m;
    last    = -1;
    for (int k = 0; k < N; k++) begin
      id = (mptr + k) % N;
      if (m[id]) begin
        e.id  = id;
        e.len = int'(cnts[id*W +: W]);
        sbq.push_back(e);
        last = id;
      end
    end
    if (last >= 0) mptr = (last + 1) % N;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (i == inj_cyc) inj = 1'b1;
      else if (inj_cyc >= 0 && i == inj_cyc + 1) begin
        inj = 1'b0;
        err_exp = 1'b1;
        chk("err_after_fault", int'(err), 1);
      end
      if (done) req = req & ~gnt;
      if (req == '0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("round_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    #10 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);

    run_round(4'b0001, 16'h0003, -1);
    run_round(4'b1111, 16'h1111, -1);
    run_round(4'b0100, 16'h0000, -1);
    run_round(4'b1111, 16'h2415, -1);
    repeat (3) run_round(4'b0010, 16'h00f0, -1);
    run_round(4'b1111, 16'hf0f0, -1);

    for (int r = 0; r < 40; r++)
      run_round(4'($urandom_range(1, 15)), 16'($urandom), -1);

    // Fault injection on q_fb during a long burst
    run_round(4'b0001, 16'h000a, 3);
    repeat (5) @(posedge clk);
    #1 chk("err_sticky", int'(err), 1);

    // Reset in the middle of a burst
    @(posedge clk); #1;
    req_cnt = 16'h7000;
    req     = 4'b1000;
    repeat (4) @(posedge clk);
    #1 chk("midburst_data", int'(data), 1);
    rst = 1'b1;
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    seen = 1'b0;
    req = '0;
    sbq.delete();
    mptr = 0;
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_round(4'b1010, 16'h3050, -1);

    repeat (5) @(posedge clk);
    #1 chk("sb_drained", sbq.size(), 0);
    chk("final_err", int'(err), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
